// File: rtl/fifo_seq_checker.sv
// Circular input buffer feeding an incrementing-sequence checker.
// Counts checked words and sequence errors, and keeps the first erroring word.
module fifo_seq_checker #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ERR_WIDTH = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 RESET_N,
  input  logic                 FIFO_WRITE,
  input  logic [31:0]          FIFO_DATA,
  output logic                 fifo_full,
  input  logic                 DRAIN_EN,
  input  logic                 CLEAR,
  output logic [31:0]          WORD_COUNT,
  output logic [ERR_WIDTH-1:0] ERROR_COUNT,
  output logic [31:0]          FIRST_ERR_DATA,
  output logic                 LOCKED,
  output logic                 ERROR,
  output logic                 OVERFLOW
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_TRACK    = 1'b1
  } state_t;

  // Buffer storage is never reset; only pointers and count are.
  logic [31:0]          r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;

  state_t               r_state;
  state_t               w_state_nx;
  logic [31:0]          r_exp;
  logic [31:0]          w_exp_nx;
  logic [31:0]          r_word_count;
  logic [31:0]          w_word_count_nx;
  logic [ERR_WIDTH-1:0] r_err_cnt;
  logic [ERR_WIDTH-1:0] w_err_cnt_nx;
  logic [31:0]          r_first_err;
  logic [31:0]          w_first_err_nx;
  logic                 r_error;
  logic                 w_error_nx;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [31:0]          w_head;
  logic                 w_mismatch;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_push     = FIFO_WRITE && !w_full;
  assign w_pop      = DRAIN_EN && (r_count != CNT_W'(0));
  assign w_head     = r_mem[r_rd_ptr];
  assign w_mismatch = (w_head != r_exp) && (w_head != 32'd0);

  assign fifo_full      = w_full;
  assign WORD_COUNT     = r_word_count;
  assign ERROR_COUNT    = r_err_cnt;
  assign FIRST_ERR_DATA = r_first_err;
  assign LOCKED         = (r_state == ST_TRACK);
  assign ERROR          = r_error;
  assign OVERFLOW       = r_overflow;

  always_ff @(posedge BUS_CLK) begin
    if (w_push && RESET_N && !CLEAR) begin
      r_mem[r_wr_ptr] <= FIFO_DATA;
    end
  end

  // Buffer pointers, occupancy and sticky overflow.
  always_ff @(posedge BUS_CLK) begin
    if (!RESET_N || CLEAR) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (FIFO_WRITE && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (!RESET_N || CLEAR) r_state <= ST_UNLOCKED;
    else                   r_state <= w_state_nx;
  end

  // Checker next state; a zero word while tracking is a source restart, not an error.
  always_comb begin
    w_state_nx      = r_state;
    w_exp_nx        = r_exp;
    w_word_count_nx = r_word_count;
    w_err_cnt_nx    = r_err_cnt;
    w_first_err_nx  = r_first_err;
    w_error_nx      = 1'b0;
    if (w_pop) begin
      w_state_nx      = ST_TRACK;
      w_exp_nx        = w_head + 32'd1;
      w_word_count_nx = r_word_count + 32'd1;
      if (r_state == ST_TRACK && w_mismatch) begin
        w_error_nx = 1'b1;
        if (r_err_cnt != {ERR_WIDTH{1'b1}}) w_err_cnt_nx = r_err_cnt + ERR_WIDTH'(1);
        if (r_err_cnt == '0) w_first_err_nx = w_head;
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (!RESET_N || CLEAR) begin
      r_exp        <= '0;
      r_word_count <= '0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
      r_error      <= 1'b0;
    end else begin
      r_exp        <= w_exp_nx;
      r_word_count <= w_word_count_nx;
      r_err_cnt    <= w_err_cnt_nx;
      r_first_err  <= w_first_err_nx;
      r_error      <= w_error_nx;
    end
  end

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Self-checking bench for fifo_seq_checker: directed scenarios plus a randomized run
// against a queue-based reference of the buffer and sequence rules.
module tb_fifo_seq_checker;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned ERR_WIDTH = 16;

  logic                 BUS_CLK = 1'b0;
  logic                 RESET_N;
  logic                 FIFO_WRITE;
  logic [31:0]          FIFO_DATA;
  logic                 fifo_full;
  logic                 DRAIN_EN;
  logic                 CLEAR;
  logic [31:0]          WORD_COUNT;
  logic [ERR_WIDTH-1:0] ERROR_COUNT;
  logic [31:0]          FIRST_ERR_DATA;
  logic                 LOCKED;
  logic                 ERROR;
  logic                 OVERFLOW;

  fifo_seq_checker #(.DEPTH(DEPTH), .ERR_WIDTH(ERR_WIDTH)) dut (
    .BUS_CLK(BUS_CLK), .RESET_N(RESET_N), .FIFO_WRITE(FIFO_WRITE), .FIFO_DATA(FIFO_DATA),
    .fifo_full(fifo_full), .DRAIN_EN(DRAIN_EN), .CLEAR(CLEAR), .WORD_COUNT(WORD_COUNT),
    .ERROR_COUNT(ERROR_COUNT), .FIRST_ERR_DATA(FIRST_ERR_DATA), .LOCKED(LOCKED),
    .ERROR(ERROR), .OVERFLOW(OVERFLOW)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0]          q[$];
  logic                 m_locked;
  logic [31:0]          m_exp;
  logic [31:0]          m_wc;
  logic [ERR_WIDTH-1:0] m_ec;
  logic [31:0]          m_first;
  logic                 m_err;
  logic                 m_ovf;

  function automatic void model_clear();
    q.delete();
    m_locked = 1'b0; m_exp = '0; m_wc = '0; m_ec = '0;
    m_first = '0; m_err = 1'b0; m_ovf = 1'b0;
  endfunction

  // One clock with the given inputs; the model applies the same edge afterwards.
  task automatic cycle(input logic wr, input logic [31:0] d, input logic dr, input logic clr);
    logic [31:0] hd;
    bit do_push, do_pop;
    FIFO_WRITE = wr; FIFO_DATA = d; DRAIN_EN = dr; CLEAR = clr;
    @(posedge BUS_CLK);
    #1;
    if (clr) begin
      model_clear();
    end else begin
      m_err   = 1'b0;
      do_push = wr && (q.size() < DEPTH);
      do_pop  = dr && (q.size() > 0);
      if (wr && !do_push) m_ovf = 1'b1;
      if (do_pop) begin
        hd = q.pop_front();
        m_wc = m_wc + 1;
        if (m_locked && hd != m_exp && hd != 32'd0) begin
          m_err = 1'b1;
          if (m_ec == 0) m_first = hd;
          if (m_ec != {ERR_WIDTH{1'b1}}) m_ec = m_ec + 1;
        end
        m_exp    = hd + 1;
        m_locked = 1'b1;
      end
      if (do_push) q.push_back(d);
    end
    FIFO_WRITE = 1'b0; DRAIN_EN = 1'b0; CLEAR = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    model_clear();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    FIFO_WRITE = 0; FIFO_DATA = 0; DRAIN_EN = 0; CLEAR = 0;
    do_reset();
    checks += 7;
    if (WORD_COUNT !== 32'd0)     begin errors++; $display("FAIL reset_wc got=%0d exp=0", WORD_COUNT); end
    if (ERROR_COUNT !== '0)       begin errors++; $display("FAIL reset_ec got=%0d exp=0", ERROR_COUNT); end
    if (FIRST_ERR_DATA !== 32'd0) begin errors++; $display("FAIL reset_first got=%0h exp=0", FIRST_ERR_DATA); end
    if (LOCKED !== 1'b0)          begin errors++; $display("FAIL reset_locked got=%b exp=0", LOCKED); end
    if (ERROR !== 1'b0)           begin errors++; $display("FAIL reset_error got=%b exp=0", ERROR); end
    if (OVERFLOW !== 1'b0)        begin errors++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
    if (fifo_full !== 1'b0)       begin errors++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
  endtask

  task automatic test_stream();
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4 && q.size() > 0; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks += 4;
    if (WORD_COUNT !== 32'd100) begin errors++; $display("FAIL stream_wc got=%0d exp=100", WORD_COUNT); end
    if (ERROR_COUNT !== '0)     begin errors++; $display("FAIL stream_ec got=%0d exp=0", ERROR_COUNT); end
    if (LOCKED !== 1'b1)        begin errors++; $display("FAIL stream_locked got=%b exp=1", LOCKED); end
    if (OVERFLOW !== 1'b0)      begin errors++; $display("FAIL stream_ovf got=%b exp=0", OVERFLOW); end
  endtask

  task automatic test_fill();
    int accepted = 0;
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (!fifo_full) begin
        cycle(1'b1, 32'(100 + accepted), 1'b0, 1'b0);
        accepted++;
        if (accepted == 15) begin
          checks++;
          if (fifo_full !== 1'b0) begin errors++; $display("FAIL fill_full15 got=%b exp=0", fifo_full); end
        end
        if (accepted == 16) begin
          checks++;
          if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full16 got=%b exp=1", fifo_full); end
        end
      end else begin
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
      end
    end
    checks += 2;
    if (accepted != 16)  begin errors++; $display("FAIL fill_accepted got=%0d exp=16", accepted); end
    if (WORD_COUNT !== 32'd0) begin errors++; $display("FAIL fill_nodrain_wc got=%0d exp=0", WORD_COUNT); end
    for (int i = 0; i < 16; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks += 4;
    if (WORD_COUNT !== 32'd16) begin errors++; $display("FAIL fill_wc got=%0d exp=16", WORD_COUNT); end
    if (ERROR_COUNT !== '0)    begin errors++; $display("FAIL fill_ec got=%0d exp=0", ERROR_COUNT); end
    if (fifo_full !== 1'b0)    begin errors++; $display("FAIL fill_empty_full got=%b exp=0", fifo_full); end
    if (OVERFLOW !== 1'b0)     begin errors++; $display("FAIL fill_ovf got=%b exp=0", OVERFLOW); end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'(200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD_0000, 1'b0, 1'b0);
    checks += 2;
    if (OVERFLOW !== 1'b1)  begin errors++; $display("FAIL ovf_set got=%b exp=1", OVERFLOW); end
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_count16 got=%b exp=1", fifo_full); end
    // Push while full with a pop in the same cycle is still dropped.
    cycle(1'b1, 32'hDEAD_0001, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks += 4;
    if (OVERFLOW !== 1'b1)     begin errors++; $display("FAIL ovf_sticky got=%b exp=1", OVERFLOW); end
    if (WORD_COUNT !== 32'd16) begin errors++; $display("FAIL ovf_wc got=%0d exp=16", WORD_COUNT); end
    if (ERROR_COUNT !== '0)    begin errors++; $display("FAIL ovf_ec got=%0d exp=0", ERROR_COUNT); end
    if (fifo_full !== 1'b0)    begin errors++; $display("FAIL ovf_drained got=%b exp=0", fifo_full); end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks += 2;
    if (OVERFLOW !== 1'b0)    begin errors++; $display("FAIL ovf_clear got=%b exp=0", OVERFLOW); end
    if (WORD_COUNT !== 32'd0) begin errors++; $display("FAIL ovf_clear_wc got=%0d exp=0", WORD_COUNT); end
  endtask

  task automatic test_errors();
    logic [31:0] seq [6];
    int pulses = 0;
    int pulse_on_nine = 0;
    seq[0] = 5; seq[1] = 6; seq[2] = 9; seq[3] = 10; seq[4] = 0; seq[5] = 1;
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(i < 6, (i < 6) ? seq[i] : 32'd0, 1'b1, 1'b0);
      checks++;
      if (ERROR !== m_err) begin errors++; $display("FAIL err_pulse cyc=%0d got=%b exp=%b", i, ERROR, m_err); end
      if (ERROR === 1'b1) begin
        pulses++;
        if (i == 3) pulse_on_nine++;
      end
    end
    checks += 5;
    if (pulses != 1)              begin errors++; $display("FAIL err_pulses got=%0d exp=1", pulses); end
    if (pulse_on_nine != 1)       begin errors++; $display("FAIL err_on_nine got=%0d exp=1", pulse_on_nine); end
    if (FIRST_ERR_DATA !== 32'd9) begin errors++; $display("FAIL err_first got=%0d exp=9", FIRST_ERR_DATA); end
    if (ERROR_COUNT !== 16'd1)    begin errors++; $display("FAIL err_ec got=%0d exp=1", ERROR_COUNT); end
    if (WORD_COUNT !== 32'd6)     begin errors++; $display("FAIL err_wc got=%0d exp=6", WORD_COUNT); end
  endtask

  task automatic test_wrap_and_reset();
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks += 2;
    if (ERROR_COUNT !== '0)   begin errors++; $display("FAIL wrap_ec got=%0d exp=0", ERROR_COUNT); end
    if (WORD_COUNT !== 32'd3) begin errors++; $display("FAIL wrap_wc got=%0d exp=3", WORD_COUNT); end
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(50 + i), 1'b0, 1'b0);
    do_reset();
    checks += 5;
    if (WORD_COUNT !== 32'd0) begin errors++; $display("FAIL rst_wc got=%0d exp=0", WORD_COUNT); end
    if (LOCKED !== 1'b0)      begin errors++; $display("FAIL rst_locked got=%b exp=0", LOCKED); end
    if (FIRST_ERR_DATA !== 32'd0 || ERROR_COUNT !== '0) begin
      errors++; $display("FAIL rst_err_state got=%0h/%0d exp=0/0", FIRST_ERR_DATA, ERROR_COUNT);
    end
    if (fifo_full !== 1'b0 || OVERFLOW !== 1'b0 || ERROR !== 1'b0) begin
      errors++; $display("FAIL rst_flags got=%b%b%b exp=000", fifo_full, OVERFLOW, ERROR);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    if (WORD_COUNT !== 32'd0) begin errors++; $display("FAIL rst_empty_wc got=%0d exp=0", WORD_COUNT); end
    cycle(1'b1, 32'd7, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks += 3;
    if (ERROR !== 1'b0)       begin errors++; $display("FAIL rst_first_err got=%b exp=0", ERROR); end
    if (LOCKED !== 1'b1)      begin errors++; $display("FAIL rst_first_locked got=%b exp=1", LOCKED); end
    if (WORD_COUNT !== 32'd1) begin errors++; $display("FAIL rst_first_wc got=%0d exp=1", WORD_COUNT); end
  endtask

  task automatic test_random();
    logic [31:0] last = 32'd0;
    logic [31:0] d;
    logic wr, dr, clr;
    int r;
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      d = 32'd0;
      else if (r == 1) d = $urandom;
      else             d = last + 1;
      wr  = ($urandom_range(0, 9) < 7);
      dr  = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 99) == 0);
      if (wr) last = d;
      cycle(wr, d, dr, clr);
      checks += 7;
      if (WORD_COUNT !== m_wc)      begin errors++; $display("FAIL rnd_wc cyc=%0d got=%0d exp=%0d", i, WORD_COUNT, m_wc); end
      if (ERROR_COUNT !== m_ec)     begin errors++; $display("FAIL rnd_ec cyc=%0d got=%0d exp=%0d", i, ERROR_COUNT, m_ec); end
      if (FIRST_ERR_DATA !== m_first) begin errors++; $display("FAIL rnd_first cyc=%0d got=%0h exp=%0h", i, FIRST_ERR_DATA, m_first); end
      if (LOCKED !== m_locked)      begin errors++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", i, LOCKED, m_locked); end
      if (ERROR !== m_err)          begin errors++; $display("FAIL rnd_error cyc=%0d got=%b exp=%b", i, ERROR, m_err); end
      if (OVERFLOW !== m_ovf)       begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, OVERFLOW, m_ovf); end
      if (fifo_full !== (q.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", i, fifo_full, q.size() == DEPTH);
      end
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_overflow();
    test_errors();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
